// File: rtl/fs_accel_pool_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fs_accel_pkg
// Description : Shared types and constants for the 2x2 / stride-2 max-pool
//               sequencer (state encoding, lane count, select width).
// Revision    : 1.0 - initial release
// ============================================================================
package fs_accel_pkg;

    // Controller states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FILL  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Compare lanes physically present in the pool datapath
    localparam int LANES = 13;

    // Width of the demux / output-mux lane selects
    localparam int SEL_W = 4;

    // Value every compare lane is cleared to (int8 minimum)
    localparam logic signed [7:0] PIX_MIN = 8'sh80;

    // Counter width for a modulus of n, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fs_accel_pool_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fs_accel_pool_ctrl_if
// Description : Pixel-in / pooled-out handshakes plus the datapath control
//               bus of the max-pool sequencer. master = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fs_accel_pool_ctrl_if;
    import fs_accel_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    logic             buf_enb;
    logic             mpbuf_ld_wrn;
    logic [SEL_W-1:0] sel_demux;
    logic             cp_enb;
    logic             cp_clr;
    logic [SEL_W-1:0] sel_mux;

    modport master (
        input  in_valid, out_ready,
        output in_ready, out_valid, buf_enb, mpbuf_ld_wrn,
               sel_demux, cp_enb, cp_clr, sel_mux
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, out_valid, buf_enb, mpbuf_ld_wrn,
               sel_demux, cp_enb, cp_clr, sel_mux
    );

endinterface
`default_nettype wire

// File: rtl/fs_accel_pool_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// Module      : fs_accel_pool_cnt
// Description : Position counters of the pool sequencer: input column, row
//               within the current row pair, row-pair index and drain lane,
//               with the wrap flags the FSM branches on.
// Revision    : 1.0 - initial release
// ============================================================================
module fs_accel_pool_cnt
    import fs_accel_pkg::*;
#(
    parameter int IN_W      = 26,
    parameter int IN_H      = 26,
    parameter int NUM_LANES = 13,
    parameter int COL_W     = 5
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic             i_col_clr,
    input  wire logic             i_col_inc,
    input  wire logic             i_lane_inc,
    input  wire logic             i_row_inc,
    input  wire logic             i_row_clr,
    output logic [COL_W-1:0]      o_col,
    output logic [SEL_W-1:0]      o_lane,
    output logic                  o_pair_end,
    output logic                  o_lane_wrap,
    output logic                  o_row_last
);

    localparam int               ROW_W       = cnt_w(IN_H / 2);
    localparam logic [COL_W-1:0] c_COL_LAST  = COL_W'(IN_W - 1);
    localparam logic [SEL_W-1:0] c_LANE_LAST = SEL_W'(NUM_LANES - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST  = ROW_W'(IN_H / 2 - 1);

    logic [COL_W-1:0] r_col;
    logic             r_rsub;
    logic [ROW_W-1:0] r_row_pair;
    logic [SEL_W-1:0] r_lane;
    logic             w_col_wrap;

    assign w_col_wrap  = (r_col == c_COL_LAST);
    assign o_col       = r_col;
    assign o_lane      = r_lane;
    assign o_pair_end  = w_col_wrap && r_rsub;
    assign o_lane_wrap = (r_lane == c_LANE_LAST);
    assign o_row_last  = (r_row_pair == c_ROW_LAST);

    // Column walks the input row; rsub flips each time a row completes
    always_ff @(posedge clk) begin
        if (!resetn || i_col_clr) begin
            r_col  <= '0;
            r_rsub <= 1'b0;
        end else if (i_col_inc) begin
            if (w_col_wrap) begin
                r_col  <= '0;
                r_rsub <= ~r_rsub;
            end else begin
                r_col  <= r_col + 1'b1;
            end
        end
    end

    // Row-pair index advances between drains and returns to 0 at map end
    always_ff @(posedge clk) begin
        if (!resetn || i_row_clr) begin
            r_row_pair <= '0;
        end else if (i_row_inc) begin
            r_row_pair <= r_row_pair + 1'b1;
        end
    end

    // Drain lane steps per handoff and wraps after the last live lane
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lane <= '0;
        end else if (i_lane_inc) begin
            r_lane <= o_lane_wrap ? '0 : r_lane + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fs_accel_pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fs_accel_pool_ctrl
// Description : Sequencer for the 2x2 / stride-2 max-pool datapath. Takes a
//               raster int8 pixel stream, steers buffer/compare lanes, and
//               drains each pooled row lane by lane downstream.
//               Optional macro FS_ACCEL_POOL_CTRL_PERF_EN adds stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module fs_accel_pool_ctrl
    import fs_accel_pkg::*;
#(
    parameter int IN_W = 26,
    parameter int IN_H = 26
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    input  wire logic            start,
    output logic                 busy,
    output logic                 done,
`ifdef FS_ACCEL_POOL_CTRL_PERF_EN
    output logic [15:0]          stall_cnt,
`endif
    fs_accel_pool_ctrl_if.master pif
);

    localparam int COL_W         = cnt_w(IN_W);
    localparam int c_DRAIN_LANES = (IN_W / 2 < LANES) ? IN_W / 2 : LANES;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_wr_pend;
    logic             r_pair_end;
    logic [SEL_W-1:0] r_sel_demux;

    logic [COL_W-1:0] w_col;
    logic [SEL_W-1:0] w_lane;
    logic [SEL_W-1:0] w_col_half;
    logic             w_pair_end;
    logic             w_lane_wrap;
    logic             w_row_last;
    logic             w_accept;
    logic             w_col_clr;
    logic             w_col_inc;
    logic             w_lane_inc;
    logic             w_row_inc;
    logic             w_row_clr;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_buf_enb;
    logic             w_ld_wrn;
    logic [SEL_W-1:0] w_sel_demux;
    logic             w_cp_enb;
    logic             w_cp_clr;
    logic [SEL_W-1:0] w_sel_mux;
    logic             w_busy;
    logic             w_done;

    fs_accel_pool_cnt #(
        .IN_W      (IN_W),
        .IN_H      (IN_H),
        .NUM_LANES (c_DRAIN_LANES),
        .COL_W     (COL_W)
    ) u_cnt (
        .clk         (clk),
        .resetn      (resetn),
        .i_col_clr   (w_col_clr),
        .i_col_inc   (w_col_inc),
        .i_lane_inc  (w_lane_inc),
        .i_row_inc   (w_row_inc),
        .i_row_clr   (w_row_clr),
        .o_col       (w_col),
        .o_lane      (w_lane),
        .o_pair_end  (w_pair_end),
        .o_lane_wrap (w_lane_wrap),
        .o_row_last  (w_row_last)
    );

    // Horizontal pairs of columns share one compare lane
    assign w_col_half = SEL_W'(w_col >> 1);

    // The buffer cannot load and write in one cycle, so a pending write blocks the next accept
    assign w_accept = (r_state == FILL) && !r_wr_pend && pif.in_valid;

    // Next-state and datapath control decode
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_buf_enb   = 1'b0;
        w_ld_wrn    = 1'b0;
        w_sel_demux = '0;
        w_cp_enb    = 1'b0;
        w_cp_clr    = 1'b0;
        w_sel_mux   = '0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_col_clr   = 1'b0;
        w_col_inc   = 1'b0;
        w_lane_inc  = 1'b0;
        w_row_inc   = 1'b0;
        w_row_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = CLR;
                end
            end
            CLR: begin
                w_busy      = 1'b1;
                w_cp_clr    = 1'b1;
                w_col_clr   = 1'b1;
                w_state_nxt = FILL;
            end
            FILL: begin
                w_busy     = 1'b1;
                w_in_ready = !r_wr_pend;
                if (w_accept) begin
                    w_buf_enb = 1'b1;
                    w_ld_wrn  = 1'b1;
                    w_col_inc = 1'b1;
                end
                if (r_wr_pend) begin
                    w_buf_enb   = 1'b1;
                    w_cp_enb    = 1'b1;
                    w_sel_demux = r_sel_demux;
                    // Leave only once the final pixel of the row pair has been written
                    if (r_pair_end) begin
                        w_state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                w_busy      = 1'b1;
                w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                w_sel_mux   = w_lane;
                if (pif.out_ready) begin
                    w_lane_inc = 1'b1;
                    if (w_lane_wrap) begin
                        if (w_row_last) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_row_inc   = 1'b1;
                            w_state_nxt = CLR;
                        end
                    end
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_row_clr   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register plus the one-deep pending-write record of the last accept
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_wr_pend   <= 1'b0;
            r_pair_end  <= 1'b0;
            r_sel_demux <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_pend <= w_accept;
            if (w_accept) begin
                r_sel_demux <= w_col_half;
                r_pair_end  <= w_pair_end;
            end
        end
    end

    assign pif.in_ready     = w_in_ready;
    assign pif.out_valid    = w_out_valid;
    assign pif.buf_enb      = w_buf_enb;
    assign pif.mpbuf_ld_wrn = w_ld_wrn;
    assign pif.sel_demux    = w_sel_demux;
    assign pif.cp_enb       = w_cp_enb;
    assign pif.cp_clr       = w_cp_clr;
    assign pif.sel_mux      = w_sel_mux;
    assign busy             = w_busy;
    assign done             = w_done;

`ifdef FS_ACCEL_POOL_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == DRAIN) && !pif.out_ready) ||
                     ((r_state == FILL)  && !pif.in_valid);

    // Saturating count of starved fill cycles and back-pressured drain cycles
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fs_accel_pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fs_accel_pool_ctrl
// Description : Self-checking bench for fs_accel_pool_ctrl (26x26 map) with a
//               behavioural pool datapath driven by the controller selects
//               and a scoreboard of golden 2x2 max values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fs_accel_pool_ctrl;

    localparam int W   = 26;
    localparam int H   = 26;
    localparam int NPX = W * H;
    localparam int NL  = W / 2;

    typedef struct {
        logic [3:0]        sel;
        logic signed [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    logic start;
    logic busy;
    logic done;
`ifdef FS_ACCEL_POOL_CTRL_PERF_EN
    logic [15:0] stall_cnt;
`endif
    logic signed [7:0] in_data;

    fs_accel_pool_ctrl_if pif ();

    fs_accel_pool_ctrl #(
        .IN_W (W),
        .IN_H (H)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .busy      (busy),
        .done      (done),
`ifdef FS_ACCEL_POOL_CTRL_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .pif       (pif)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   n_done = 0;
    exp_t sb_q[$];
    logic signed [7:0] pix [0:NPX-1];

    // Behavioural datapath and protocol tracking state
    logic signed [7:0] m_buf;
    logic signed [7:0] m_lane [0:NL-1];
    bit         prev_acc = 1'b0;
    bit         prev_stall = 1'b0;
    logic [3:0] prev_dsel = '0;
    logic [3:0] prev_mux = '0;
    int         exp_col = 0;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic logic signed [7:0] max4(input logic signed [7:0] a, input logic signed [7:0] b,
                                               input logic signed [7:0] c, input logic signed [7:0] d);
        logic signed [7:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Scoreboard consumer, protocol checks and datapath model, sampled mid-cycle
    always @(negedge clk) begin
        if (!resetn) begin
            prev_acc   = 1'b0;
            prev_stall = 1'b0;
            exp_col    = 0;
        end else begin
            if (pif.out_valid && pif.out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("pool_sel", {28'd0, pif.sel_mux}, {28'd0, e.sel});
                    if (pif.sel_mux < NL) check("pool_val", {24'd0, m_lane[pif.sel_mux]}, {24'd0, e.val});
                    else check("pool_sel_range", 32'd1, 32'd0);
                end
            end
            if (prev_stall) begin
                check("stall_valid", {31'd0, pif.out_valid}, 32'd1);
                check("stall_sel", {28'd0, pif.sel_mux}, {28'd0, prev_mux});
            end
            check("cp_enb_follow", {31'd0, pif.cp_enb}, {31'd0, prev_acc});
            if (prev_acc) begin
                check("ready_after_acc", {31'd0, pif.in_ready}, 32'd0);
                check("demux_sel", {28'd0, pif.sel_demux}, {28'd0, prev_dsel});
                check("wr_phase", {30'd0, pif.buf_enb, pif.mpbuf_ld_wrn}, 32'd2);
            end
            if (done) begin
                n_done++;
                check("busy_low_on_done", {31'd0, busy}, 32'd0);
            end
            prev_stall = pif.out_valid && !pif.out_ready;
            prev_mux   = pif.sel_mux;
            prev_acc   = pif.in_valid && pif.in_ready;
            if (prev_acc) begin
                prev_dsel = 4'(exp_col / 2);
                exp_col   = (exp_col + 1) % W;
            end
            if (pif.cp_clr) begin
                for (int i = 0; i < NL; i++) m_lane[i] = 8'sh80;
            end
            if (pif.cp_enb && pif.sel_demux < NL) begin
                if (m_buf > m_lane[pif.sel_demux]) m_lane[pif.sel_demux] = m_buf;
            end
            if (pif.buf_enb && pif.mpbuf_ld_wrn) m_buf = in_data;
        end
    end

    // New pixel map; the golden pooled results are queued in drain order
    task automatic load_map(input bit directed);
        for (int i = 0; i < NPX; i++) pix[i] = 8'($urandom);
        if (directed) begin
            pix[0]  = 8'sd1;   pix[1]  = 8'sd5;   pix[W]   = 8'sd2;   pix[W+1] = 8'sd0;
            pix[2]  = -8'sd3;  pix[3]  = -8'sd7;  pix[W+2] = -8'sd1;  pix[W+3] = 8'sh80;
            pix[4]  = 8'sh80;  pix[5]  = 8'sh80;  pix[W+4] = 8'sh80;  pix[W+5] = 8'sh80;
        end
        sb_q.delete();
        for (int rp = 0; rp < H / 2; rp++) begin
            for (int l = 0; l < NL; l++) begin
                exp_t e;
                e.sel = 4'(l);
                e.val = max4(pix[2*rp*W + 2*l], pix[2*rp*W + 2*l + 1],
                             pix[(2*rp+1)*W + 2*l], pix[(2*rp+1)*W + 2*l + 1]);
                sb_q.push_back(e);
            end
        end
    endtask

    // Start a map and stream it; optional in_valid toggling, lane-3 stall, stray start, early abort
    task automatic run_map(input bit toggle, input bit do_stall, input bit poke_start, input int abort_after);
        int idx;
        int cyc;
        int stall_left;
        bit stalled;
        bit seen_done;
        bit ph;
        idx = 0; cyc = 0; stall_left = 0; stalled = 1'b0; seen_done = 1'b0; ph = 1'b1;
        n_out = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen_done && cyc < 20000) begin
            pif.in_valid  = toggle ? ph : 1'b1;
            ph            = ~ph;
            in_data       = (idx < NPX) ? pix[idx] : 8'sh55;
            pif.out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            start = poke_start && (cyc == 40);
            @(negedge clk);
            if (pif.in_valid && pif.in_ready) idx++;
            if (do_stall && !stalled && pif.out_valid && pif.out_ready && pif.sel_mux == 4'd2) begin
                stalled    = 1'b1;
                stall_left = 10;
            end
            if (done) seen_done = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (abort_after != 0 && idx == abort_after) break;
        end
        start         = 1'b0;
        pif.in_valid  = 1'b1;
        pif.out_ready = 1'b1;
        if (abort_after == 0) check("map_finished", {31'd0, seen_done}, 32'd1);
    endtask

    initial begin
        int done_before;
        resetn        = 1'b0;
        start         = 1'b0;
        pif.in_valid  = 1'b0;
        pif.out_ready = 1'b1;
        in_data       = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("reset_outputs", {16'd0, pif.in_ready, pif.out_valid, pif.buf_enb, pif.mpbuf_ld_wrn,
                                pif.cp_enb, pif.cp_clr, busy, done, pif.sel_demux, pif.sel_mux}, 32'd0);

        // in_valid while IDLE must not be taken
        @(posedge clk); #1;
        pif.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_no_ready", {29'd0, pif.in_ready, pif.buf_enb, busy}, 32'd0);
            @(posedge clk); #1;
        end

        // Directed corner windows, stall on lane 3, stray start mid-fill
        load_map(1'b1);
        run_map(1'b0, 1'b1, 1'b1, 0);
        check("mapA_handoffs", n_out, NL * H / 2);
        check("mapA_sb_empty", sb_q.size(), 0);
        check("mapA_done_cnt", n_done, 1);
`ifdef FS_ACCEL_POOL_CTRL_PERF_EN
        check("mapA_stall_cnt", {16'd0, stall_cnt}, 32'd10);
`endif
        @(negedge clk);
        check("idle_after_map", {30'd0, busy, pif.in_ready}, 32'd0);
        @(posedge clk); #1;

        // in_valid toggling every cycle
        load_map(1'b0);
        run_map(1'b1, 1'b0, 1'b0, 0);
        check("mapB_handoffs", n_out, NL * H / 2);
        check("mapB_sb_empty", sb_q.size(), 0);
        check("mapB_done_cnt", n_done, 2);

        // Abort after 5 pixels with a one-cycle reset, then a full clean map
        done_before = n_done;
        load_map(1'b0);
        run_map(1'b0, 1'b0, 1'b0, 5);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("abort_outputs", {16'd0, pif.in_ready, pif.out_valid, pif.buf_enb, pif.mpbuf_ld_wrn,
                                pif.cp_enb, pif.cp_clr, busy, done, pif.sel_demux, pif.sel_mux}, 32'd0);
        @(posedge clk); #1;
        check("abort_no_done", n_done, done_before);
        load_map(1'b0);
        run_map(1'b0, 1'b0, 1'b0, 0);
        check("mapD_handoffs", n_out, NL * H / 2);
        check("mapD_sb_empty", sb_q.size(), 0);
        check("mapD_done_once", n_done, done_before + 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
